// File: rtl/alu_pkg.sv
// Shared types for the ALU issue unit: opcodes, FSM states and the
// positions of the instruction fields.
package alu_pkg;

  typedef enum logic [3:0] {
    OPC_MOV = 4'd0,
    OPC_CMP = 4'd1,
    OPC_ADD = 4'd2,
    OPC_SUB = 4'd3,
    OPC_MUL = 4'd4,
    OPC_DIV = 4'd5,
    OPC_XOR = 4'd6,
    OPC_AND = 4'd7,
    OPC_NOT = 4'd8,
    OPC_MOD = 4'd9
  } opcode_e;

  localparam logic [3:0] OPC_LAST = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 10;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 6;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 2;
  localparam int RS2_LSB = 0;

  function automatic logic opc_legal(input logic [3:0] opc);
    return opc <= OPC_LAST;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// REGS x N register file: one synchronous write port, two asynchronous
// operand read ports and an asynchronous debug read port.
module alu_regfile #(
  parameter int N    = 4,
  parameter int REGS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [2:0]   waddr_i,
  input  logic [N-1:0] wdata_i,
  input  logic [2:0]   raddr_a_i,
  input  logic [2:0]   raddr_b_i,
  input  logic [2:0]   dbg_addr_i,
  output logic [N-1:0] rdata_a_o,
  output logic [N-1:0] rdata_b_o,
  output logic [N-1:0] dbg_data_o
);

  logic [N-1:0] mem_q [REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = mem_q[raddr_a_i];
  assign rdata_b_o  = mem_q[raddr_b_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue.sv
// Issues one instruction at a time to an external ALU and retires it into
// the register file four cycles later.
//   state    | meaning
//   ST_IDLE  | ready, waiting for instr_valid
//   ST_ISSUE | registered operands/opcode presented to the ALU
//   ST_EXEC  | ALU result and flags captured into holding registers
//   ST_WB    | result/flags committed, done (and illegal) pulse
module alu_issue
  import alu_pkg::*;
#(
  parameter int N    = 4,
  parameter int REGS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [15:0]  instr,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_select,
  input  logic [N-1:0] alu_result,
  input  logic [1:0]   alu_flags,
  output logic         done,
  output logic         illegal,
  output logic [1:0]   flags_q,
  input  logic [2:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);

  state_e       state_q, state_d;
  logic [3:0]   opc_q;
  logic [2:0]   rd_q;
  logic [N-1:0] res_q;
  logic [1:0]   hold_flags_q;
  logic [N-1:0] alu_a_q, alu_b_q;
  logic [3:0]   sel_q;
  logic [1:0]   flags_arch_q;

  logic [3:0]   opc_in;
  logic [2:0]   rd_in, rs1_in, rs2_in;
  logic [N-1:0] rdata_a, rdata_b;
  logic         accept, wb_legal, rf_we;
  logic         unused_instr_bits;

  assign opc_in = instr[OPC_MSB:OPC_LSB];
  assign rd_in  = instr[RD_MSB:RD_LSB];
  assign rs1_in = instr[RS1_MSB:RS1_LSB];
  assign rs2_in = instr[RS2_MSB:RS2_LSB];
  assign unused_instr_bits = ^{instr[11], instr[7], instr[3]};

  assign instr_ready = (state_q == ST_IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;
  assign done        = (state_q == ST_WB) && !rst;
  assign wb_legal    = opc_legal(opc_q);
  assign illegal     = done && !wb_legal;
  assign rf_we       = done && wb_legal && (opc_q != OPC_CMP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      opc_q        <= '0;
      rd_q         <= '0;
      res_q        <= '0;
      hold_flags_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      sel_q        <= '0;
      flags_arch_q <= '0;
    end else begin
      state_q <= state_d;
      // Operands are read at acceptance so rd==rs still sees pre-write values.
      if (accept) begin
        opc_q   <= opc_in;
        rd_q    <= rd_in;
        alu_a_q <= rdata_a;
        alu_b_q <= rdata_b;
        sel_q   <= opc_legal(opc_in) ? opc_in : OPC_MOV;
      end
      if (state_q == ST_EXEC) begin
        res_q        <= alu_result;
        hold_flags_q <= alu_flags;
      end
      if (state_q == ST_WB && wb_legal) flags_arch_q <= hold_flags_q;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = sel_q;
  assign flags_q    = flags_arch_q;

  alu_regfile #(.N(N), .REGS(REGS)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (res_q),
    .raddr_a_i  (rs1_in),
    .raddr_b_i  (rs2_in),
    .dbg_addr_i (dbg_addr),
    .rdata_a_o  (rdata_a),
    .rdata_b_o  (rdata_b),
    .dbg_data_o (dbg_data)
  );

endmodule
